debounce_edge_detect: RTL and testbench
=======================================

// Module: debounce_edge_detect
//
// PURPOSE
// Downstream consumer of the single-bit registered input flop. It re-synchronises
// that bit and debounces it with a qualification counter and a 4-state FSM.
// Outputs are a clean level plus one-cycle rise/fall pulses for control logic.
// Typical use is push-buttons and slide switches on the board I/O path.
//
// PARAMETERS
// STABLE_CYCLES  50000  consecutive cycles din must hold a new level before it is accepted (>=1)
// CNT_WIDTH      16     qualification counter width; must hold STABLE_CYCLES-1
//
// PORTS
// clk     input   1  system clock; all state updates on rising edge
// rst     input   1  synchronous, active-high reset
// din     input   1  raw/registered level from the input flop (may bounce, async-safe)
// dout    output  1  debounced level (registered)
// rise    output  1  one-cycle pulse when dout goes 0->1
// fall    output  1  one-cycle pulse when dout goes 1->0
// busy    output  1  high while a candidate transition is being qualified
//
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): sync1=sync2=0, state=S_LOW, cnt=0, dout=0, rise=0, fall=0, busy=0.
// - Reset has priority over everything. Asserting it mid-qualification aborts the candidate.
// - After reset release, a high din must fully re-qualify; reset itself never produces rise/fall.
// - Synchroniser: sync1<=din; sync2<=sync1. The FSM sees only sync2 (2-cycle input latency).
// - FSM states: S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L.
// - S_LOW: sync2=1 -> S_WAIT_H, cnt<=0; else stay.
// - S_WAIT_H:
//   - sync2=0 -> S_LOW, cnt<=0. Bounce is rejected; no pulse.
//   - Else if cnt==STABLE_CYCLES-1 -> S_HIGH, dout<=1, rise<=1.
//   - Else cnt<=cnt+1.
// - S_HIGH: sync2=0 -> S_WAIT_L, cnt<=0; else stay.
// - S_WAIT_L: mirror of S_WAIT_H.
//   - sync2=1 -> S_HIGH, no pulse.
//   - cnt==STABLE_CYCLES-1 -> S_LOW, dout<=0, fall<=1.
// - rise/fall are registered and high for exactly one cycle.
//   - They assert in the same cycle dout changes.
//   - They are never high simultaneously.
//   - They default to 0 every cycle unless set.
// - busy = (state==S_WAIT_H || state==S_WAIT_L), registered with the state.
// - Latency: din stable from sampling edge k -> dout changes after edge k+STABLE_CYCLES+2.
// - Counter never wraps: it is cleared on every entry to a WAIT state and stops at STABLE_CYCLES-1.
// - STABLE_CYCLES=1: a candidate is accepted on the edge after entering WAIT.
// - Any glitch shorter than STABLE_CYCLES cycles (as seen at sync2) leaves dout unchanged.
//
// TESTING (bench uses STABLE_CYCLES=4)
// 1. Reset: hold rst 3 cycles with din=1 -> dout=0, rise=fall=busy=0.
//    After release, din held 1 -> rise once, 6 edges after release.
// 2. Clean press: din 0->1 before edge k, held -> busy from k+2.
//    dout=1 and rise=1 (single cycle) after edge k+6; no fall.
// 3. Bounce reject: din 1 for 2 cycles, 0 for 1, 1 for 3, then 0 -> dout stays 0.
//    rise never asserts; busy toggles and returns low.
// 4. Release: from S_HIGH, din 1->0 held -> fall=1 one cycle, dout=0 after edge k+6.
//    Bounce in S_WAIT_L returns to S_HIGH with no pulse.
// 5. Reset mid-operation: rst asserted in S_WAIT_H when cnt=2 -> next cycle state S_LOW, cnt=0, busy=0.
//    No rise occurs until 4 fresh stable cycles after release.
// 6. Back-to-back: press qualified, then release immediately after rise -> exactly one rise and one fall.
//    They are separated by >=STABLE_CYCLES+1 cycles; never overlapping.

Source files
------------

// File: rtl/debounce_edge_detect.sv
// Two-flop synchroniser followed by a qualification counter and 4-state FSM.
// Produces a debounced level plus registered one-cycle rise/fall pulses.
module debounce_edge_detect #(
   parameter int STABLE_CYCLES = 50000,
   parameter int CNT_WIDTH     = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic [1:0] {
      S_LOW    = 2'd0,
      S_WAIT_H = 2'd1,
      S_HIGH   = 2'd2,
      S_WAIT_L = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

   logic                 sync1;
   logic                 sync2;
   state_t               state;
   state_t               state_n;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_n;
   logic                 dout_n;
   logic                 rise_n;
   logic                 fall_n;
   logic                 busy_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // The counter is cleared on every WAIT entry and holds at CNT_LAST, so it never wraps.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dout_n  = dout;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      case (state)
         S_LOW: begin
            if (sync2) begin
               state_n = S_WAIT_H;
               cnt_n   = '0;
            end
         end
         S_WAIT_H: begin
            if (!sync2) begin
               state_n = S_LOW;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = S_HIGH;
               dout_n  = 1'b1;
               rise_n  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_HIGH: begin
            if (!sync2) begin
               state_n = S_WAIT_L;
               cnt_n   = '0;
            end
         end
         S_WAIT_L: begin
            if (sync2) begin
               state_n = S_HIGH;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = S_LOW;
               dout_n  = 1'b0;
               fall_n  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = S_LOW;
            cnt_n   = '0;
            dout_n  = 1'b0;
         end
      endcase
      busy_n = (state_n == S_WAIT_H) || (state_n == S_WAIT_L);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_LOW;
         cnt   <= '0;
         dout  <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         dout  <= dout_n;
         rise  <= rise_n;
         fall  <= fall_n;
         busy  <= busy_n;
      end
   end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: run-length reference model feeding an expected
// queue, directed scenarios with latency checks, then random bouncing stimulus.
module tb_debounce_edge_detect;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic dout, rise, fall, busy;

   always #5 clk = ~clk;

   debounce_edge_detect #(
      .STABLE_CYCLES(N),
      .CNT_WIDTH(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .din (din),
      .dout(dout),
      .rise(rise),
      .fall(fall),
      .busy(busy)
   );

   int checks   = 0;
   int failures = 0;
   logic [3:0] exp_q[$];

   // Reference: a new level is taken once sync2 has differed from it at N+1 consecutive edges.
   logic m_s1  = 1'b0;
   logic m_s2  = 1'b0;
   logic m_lvl = 1'b0;
   int   m_run = 0;

   int edge_n    = 0;
   int rise_cnt  = 0;
   int fall_cnt  = 0;
   int rise_edge = 0;
   int fall_edge = 0;
   bit busy_seen = 1'b0;
   int k;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic d, input logic r, output logic [3:0] e);
      logic p_rise, p_fall;
      p_rise = 1'b0;
      p_fall = 1'b0;
      if (r) begin
         m_s1  = 1'b0;
         m_s2  = 1'b0;
         m_lvl = 1'b0;
         m_run = 0;
      end else begin
         if (m_s2 != m_lvl) begin
            m_run++;
            if (m_run == N + 1) begin
               m_lvl  = ~m_lvl;
               p_rise = m_lvl;
               p_fall = ~m_lvl;
               m_run  = 0;
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = d;
      end
      e = {m_lvl, p_rise, p_fall, (m_run != 0)};
   endtask

   task automatic step(input logic d, input logic r, input string tag);
      logic [3:0] e;
      logic [3:0] got;
      @(negedge clk);
      din = d;
      rst = r;
      model_step(d, r, e);
      exp_q.push_back(e);
      @(posedge clk);
      edge_n++;
      #1;
      got = {dout, rise, fall, busy};
      e   = exp_q.pop_front();
      check({tag, "_outs"}, 32'(got), 32'(e));
      check({tag, "_no_overlap"}, 32'(rise & fall), 32'd0);
      if (rise) begin
         rise_cnt++;
         rise_edge = edge_n;
      end
      if (fall) begin
         fall_cnt++;
         fall_edge = edge_n;
      end
      if (busy) busy_seen = 1'b1;
   endtask

   task automatic clear_stats();
      rise_cnt  = 0;
      fall_cnt  = 0;
      busy_seen = 1'b0;
   endtask

   task automatic settle_low();
      step(1'b0, 1'b1, "settle");
      step(1'b0, 1'b1, "settle");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "settle");
      clear_stats();
   endtask

   initial begin
      // 1: reset with din high, then full re-qualification
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "t1_rst");
      check("t1_rst_dout", 32'(dout), 32'd0);
      check("t1_rst_busy", 32'(busy), 32'd0);
      clear_stats();
      k = edge_n + 1;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "t1_hold");
      check("t1_rise_cnt", 32'(rise_cnt), 32'd1);
      check("t1_rise_lat", 32'(rise_edge - k), 32'd6);

      // 2: clean press
      settle_low();
      k = edge_n + 1;
      step(1'b1, 1'b0, "t2_press");
      step(1'b1, 1'b0, "t2_press");
      check("t2_busy_pre", 32'(busy), 32'd0);
      step(1'b1, 1'b0, "t2_press");
      check("t2_busy_k2", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "t2_press");
      check("t2_rise_cnt", 32'(rise_cnt), 32'd1);
      check("t2_rise_lat", 32'(rise_edge - k), 32'd6);
      check("t2_fall_cnt", 32'(fall_cnt), 32'd0);
      check("t2_dout", 32'(dout), 32'd1);

      // 3: bounce rejected from low
      settle_low();
      step(1'b1, 1'b0, "t3_b");
      step(1'b1, 1'b0, "t3_b");
      step(1'b0, 1'b0, "t3_b");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "t3_b");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "t3_b");
      check("t3_rise_cnt", 32'(rise_cnt), 32'd0);
      check("t3_busy_seen", 32'(busy_seen), 32'd1);
      check("t3_busy_end", 32'(busy), 32'd0);
      check("t3_dout", 32'(dout), 32'd0);

      // 4: release, then a bounce while qualifying low
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "t4_up");
      clear_stats();
      k = edge_n + 1;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "t4_rel");
      check("t4_fall_cnt", 32'(fall_cnt), 32'd1);
      check("t4_fall_lat", 32'(fall_edge - k), 32'd6);
      check("t4_dout", 32'(dout), 32'd0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "t4_up2");
      clear_stats();
      step(1'b0, 1'b0, "t4_bnc");
      step(1'b0, 1'b0, "t4_bnc");
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "t4_bnc");
      check("t4_bnc_fall", 32'(fall_cnt), 32'd0);
      check("t4_bnc_busy", 32'(busy_seen), 32'd1);
      check("t4_bnc_dout", 32'(dout), 32'd1);

      // 5: reset while qualifying high with cnt==2
      settle_low();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "t5_q");
      check("t5_busy_mid", 32'(busy), 32'd1);
      step(1'b1, 1'b1, "t5_rst");
      check("t5_busy_rst", 32'(busy), 32'd0);
      check("t5_dout_rst", 32'(dout), 32'd0);
      clear_stats();
      k = edge_n + 1;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "t5_req");
      check("t5_rise_cnt", 32'(rise_cnt), 32'd1);
      check("t5_rise_lat", 32'(rise_edge - k), 32'd6);

      // 6: release immediately after the rise pulse
      settle_low();
      for (int i = 0; i < 20 && rise_cnt == 0; i++) step(1'b1, 1'b0, "t6_press");
      check("t6_rise_seen", 32'(rise_cnt), 32'd1);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, "t6_rel");
      check("t6_rise_cnt", 32'(rise_cnt), 32'd1);
      check("t6_fall_cnt", 32'(fall_cnt), 32'd1);
      check("t6_gap", 32'(fall_edge - rise_edge >= N + 1), 32'd1);

      // random bouncing segments with occasional resets
      for (int s = 0; s < 50; s++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++)
            step(lvl, ($urandom_range(0, 39) == 0), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
